// File: rtl/branch_predictor_gshare_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types and helpers for the gshare branch predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // The entry record is sized for the widest legal configuration; narrower
  // instances zero-extend into it.
  localparam int BP_TAG_MAX_W    = 30;
  localparam int BP_TARGET_MAX_W = 64;
  localparam int BP_CTR_MAX_W    = 8;

  typedef struct packed {
    logic                       valid;
    logic [BP_TAG_MAX_W-1:0]    tag;
    logic [BP_TARGET_MAX_W-1:0] target;
  } btb_entry_t;

  localparam logic [BP_CTR_MAX_W-1:0] BP_WEAK_TAKEN_C2 = 8'd2;

  function automatic logic [BP_CTR_MAX_W-1:0] weak_taken(input int unsigned width);
    return BP_CTR_MAX_W'(32'd1 << (width - 32'd1));
  endfunction

  function automatic logic [BP_CTR_MAX_W-1:0] sat_update(
    input logic [BP_CTR_MAX_W-1:0] counter,
    input logic                    taken,
    input int unsigned             width
  );
    logic [BP_CTR_MAX_W-1:0] v_max;
    v_max = BP_CTR_MAX_W'((32'd1 << width) - 32'd1);
    if (taken) begin
      return (counter >= v_max) ? v_max : counter + BP_CTR_MAX_W'(1);
    end
    return (counter == '0) ? '0 : counter - BP_CTR_MAX_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_gshare_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_gshare_if
//  Description : Fetch-lookup and execute-update bundle of the predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_gshare_if #(
  parameter int TARGET_WIDTH = 32,
  parameter int HIST_BITS    = 8
);
  logic                    fetchValid;
  logic [31:0]             fetchPc;
  logic                    fetchHit;
  logic                    fetchTaken;
  logic [TARGET_WIDTH-1:0] fetchTarget;
  logic [HIST_BITS-1:0]    fetchGhr;
  logic                    exValid;
  logic [31:0]             exPc;
  logic                    exTaken;
  logic [TARGET_WIDTH-1:0] exTarget;
  logic [HIST_BITS-1:0]    exGhr;
  logic                    exMispredict;

  modport master (
    output fetchValid, fetchPc, exValid, exPc, exTaken, exTarget, exGhr, exMispredict,
    input  fetchHit, fetchTaken, fetchTarget, fetchGhr
  );

  modport slave (
    input  fetchValid, fetchPc, exValid, exPc, exTaken, exTarget, exGhr, exMispredict,
    output fetchHit, fetchTaken, fetchTarget, fetchGhr
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_gshare_btb.sv
`default_nettype none
// ============================================================================
//  Module      : btb_set_assoc
//  Description : Set-associative BTB with round-robin victim selection.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_set_assoc
  import bp_pkg::*;
#(
  parameter int SETS     = 16,
  parameter int WAYS     = 2,
  parameter int TAG_W    = 26,
  parameter int TARGET_W = 32
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic [$clog2(SETS)-1:0]       i_rd_set,
  input  wire logic [TAG_W-1:0]              i_rd_tag,
  output logic                               o_rd_hit,
  output logic [TARGET_W-1:0]                o_rd_target,
  input  wire logic                          i_wr_valid,
  input  wire logic [$clog2(SETS)-1:0]       i_wr_set,
  input  wire logic [TAG_W-1:0]              i_wr_tag,
  input  wire logic                          i_wr_taken,
  input  wire logic [TARGET_W-1:0]           i_wr_target
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic                r_valid  [SETS][WAYS];
  logic [TAG_W-1:0]    r_tag    [SETS][WAYS];
  logic [TARGET_W-1:0] r_target [SETS][WAYS];
  logic [WAY_W-1:0]    r_rr     [SETS];

  btb_entry_t       w_rd_ent [WAYS];
  logic             w_unused_tgt_hi;
  logic             w_wr_hit;
  logic [WAY_W-1:0] w_wr_hit_way;
  logic             w_inv_found;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_victim;
  logic [WAY_W-1:0] w_wr_way;
  logic             w_wr_en;
  logic             w_alloc;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_rd_ent[w].valid  = r_valid[i_rd_set][w];
      w_rd_ent[w].tag    = BP_TAG_MAX_W'(r_tag[i_rd_set][w]);
      w_rd_ent[w].target = BP_TARGET_MAX_W'(r_target[i_rd_set][w]);
    end
  end

  // Descending scan so the lowest matching way is the one that sticks.
  always_comb begin
    o_rd_hit    = 1'b0;
    o_rd_target = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_rd_ent[w].valid && (w_rd_ent[w].tag == BP_TAG_MAX_W'(i_rd_tag))) begin
        o_rd_hit    = 1'b1;
        o_rd_target = TARGET_W'(w_rd_ent[w].target);
      end
    end
  end

  always_comb begin
    w_unused_tgt_hi = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      w_unused_tgt_hi = w_unused_tgt_hi ^ (^w_rd_ent[w].target);
    end
  end

  always_comb begin
    w_wr_hit     = 1'b0;
    w_wr_hit_way = '0;
    w_inv_found  = 1'b0;
    w_inv_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[i_wr_set][w] && (r_tag[i_wr_set][w] == i_wr_tag)) begin
        w_wr_hit     = 1'b1;
        w_wr_hit_way = WAY_W'(w);
      end
      if (!r_valid[i_wr_set][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
  end

  assign w_victim = w_inv_found ? w_inv_way : r_rr[i_wr_set];
  assign w_wr_way = w_wr_hit ? w_wr_hit_way : w_victim;
  assign w_wr_en  = i_wr_valid & i_wr_taken;
  assign w_alloc  = w_wr_en & ~w_wr_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
        end
      end
    end else if (w_alloc) begin
      r_valid[i_wr_set][w_victim] <= 1'b1;
      r_rr[i_wr_set] <= (r_rr[i_wr_set] == WAY_W'(WAYS - 1)) ? '0
                                                              : r_rr[i_wr_set] + WAY_W'(1);
    end
  end

  // Tag/target payload carries no reset; valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) begin
      r_target[i_wr_set][w_wr_way] <= i_wr_target;
      if (!w_wr_hit) begin
        r_tag[i_wr_set][w_wr_way] <= i_wr_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_gshare
//  Description : BTB plus gshare PHT with a speculative, recoverable GHR.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int BTB_SETS      = 16,
  parameter int BTB_WAYS      = 2,
  parameter int PHT_ENTRIES   = 256,
  parameter int HIST_BITS     = 8,
  parameter int COUNTER_WIDTH = 2,
  parameter int TARGET_WIDTH  = 32
) (
  input wire logic                 clk,
  input wire logic                 rst,
  branch_predictor_gshare_if.slave io_bp
);
  localparam int SET_W = $clog2(BTB_SETS);
  localparam int PHT_W = $clog2(PHT_ENTRIES);
  localparam int TAG_W = 30 - SET_W;
  localparam logic [COUNTER_WIDTH-1:0] c_weak_taken = COUNTER_WIDTH'(weak_taken(COUNTER_WIDTH));

  logic [COUNTER_WIDTH-1:0] r_pht [PHT_ENTRIES];
  logic [HIST_BITS-1:0]     r_ghr;

  logic                     w_hit;
  logic                     w_taken;
  logic [TARGET_WIDTH-1:0]  w_target;
  logic [PHT_W-1:0]         w_fetch_idx;
  logic [PHT_W-1:0]         w_ex_idx;
  logic [COUNTER_WIDTH-1:0] w_ctr_next;
  logic [HIST_BITS-1:0]     w_ghr_mis;
  logic [HIST_BITS-1:0]     w_ghr_spec;
  logic                     w_unused_pc_lo;

  assign w_unused_pc_lo = ^{io_bp.fetchPc[1:0], io_bp.exPc[1:0]};

  assign w_fetch_idx = io_bp.fetchPc[PHT_W+1:2] ^ PHT_W'(r_ghr);
  assign w_ex_idx    = io_bp.exPc[PHT_W+1:2] ^ PHT_W'(io_bp.exGhr);

  btb_set_assoc #(
    .SETS     (BTB_SETS),
    .WAYS     (BTB_WAYS),
    .TAG_W    (TAG_W),
    .TARGET_W (TARGET_WIDTH)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .i_rd_set    (io_bp.fetchPc[SET_W+1:2]),
    .i_rd_tag    (io_bp.fetchPc[31:SET_W+2]),
    .o_rd_hit    (w_hit),
    .o_rd_target (w_target),
    .i_wr_valid  (io_bp.exValid),
    .i_wr_set    (io_bp.exPc[SET_W+1:2]),
    .i_wr_tag    (io_bp.exPc[31:SET_W+2]),
    .i_wr_taken  (io_bp.exTaken),
    .i_wr_target (io_bp.exTarget)
  );

  assign w_taken    = w_hit & r_pht[w_fetch_idx][COUNTER_WIDTH-1];
  assign w_ctr_next = COUNTER_WIDTH'(sat_update(BP_CTR_MAX_W'(r_pht[w_ex_idx]),
                                                io_bp.exTaken, COUNTER_WIDTH));

  generate
    if (HIST_BITS == 1) begin : g_hist_one
      assign w_ghr_mis  = io_bp.exTaken;
      assign w_ghr_spec = w_taken;
    end else begin : g_hist_multi
      assign w_ghr_mis  = {io_bp.exGhr[HIST_BITS-2:0], io_bp.exTaken};
      assign w_ghr_spec = {r_ghr[HIST_BITS-2:0], w_taken};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        r_pht[i] <= c_weak_taken;
      end
    end else if (io_bp.exValid) begin
      r_pht[w_ex_idx] <= w_ctr_next;
    end
  end

  // A resolved mispredict overrides any speculative shift in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (io_bp.exValid && io_bp.exMispredict) begin
      r_ghr <= w_ghr_mis;
    end else if (io_bp.fetchValid && w_hit) begin
      r_ghr <= w_ghr_spec;
    end
  end

  assign io_bp.fetchHit    = w_hit;
  assign io_bp.fetchTaken  = w_taken;
  assign io_bp.fetchTarget = w_target;
  assign io_bp.fetchGhr    = r_ghr;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_gshare
//  Description : Directed and randomized checks of the gshare predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_gshare;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_gshare_if #(.TARGET_WIDTH(32), .HIST_BITS(8)) bp ();

  branch_predictor_gshare #(
    .BTB_SETS(16), .BTB_WAYS(2), .PHT_ENTRIES(256),
    .HIST_BITS(8), .COUNTER_WIDTH(2), .TARGET_WIDTH(32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bp (bp)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: plain arrays indexed by set/way, counters as integers 0..3.
  bit          m_valid [16][2];
  int unsigned m_tag   [16][2];
  logic [31:0] m_tgt   [16][2];
  int          m_rr    [16];
  int          m_pht   [256];
  int          m_ghr;

  function automatic int m_idx(input logic [31:0] pc, input int ghr);
    return int'((pc >> 2) & 32'hFF) ^ (ghr & 255);
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 16; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 2; w++) m_valid[s][w] = 0;
    end
    for (int i = 0; i < 256; i++) m_pht[i] = 2;
    m_ghr = 0;
  endtask

  task automatic m_lookup(input logic [31:0] pc, output bit hit, output logic [31:0] tgt,
                          output int way);
    int s;
    int unsigned t;
    s = int'((pc >> 2) & 32'hF);
    t = pc >> 6;
    hit = 0; tgt = '0; way = -1;
    for (int w = 0; w < 2; w++) begin
      if (!hit && m_valid[s][w] && m_tag[s][w] == t) begin
        hit = 1; tgt = m_tgt[s][w]; way = w;
      end
    end
  endtask

  task automatic m_predict(input logic [31:0] pc, output bit hit, output bit taken,
                           output logic [31:0] tgt);
    int way;
    m_lookup(pc, hit, tgt, way);
    taken = hit && (m_pht[m_idx(pc, m_ghr)] >= 2);
  endtask

  task automatic m_step();
    bit fh, ft, eh;
    logic [31:0] ftg, etg;
    int way, new_ghr, pi, s, victim;
    m_predict(bp.fetchPc, fh, ft, ftg);
    new_ghr = m_ghr;
    if (bp.exValid && bp.exMispredict)
      new_ghr = ((int'(bp.exGhr) << 1) | int'(bp.exTaken)) & 255;
    else if (bp.fetchValid && fh)
      new_ghr = ((m_ghr << 1) | int'(ft)) & 255;
    if (bp.exValid) begin
      pi = m_idx(bp.exPc, int'(bp.exGhr));
      if (bp.exTaken) m_pht[pi] = (m_pht[pi] < 3) ? m_pht[pi] + 1 : 3;
      else            m_pht[pi] = (m_pht[pi] > 0) ? m_pht[pi] - 1 : 0;
      m_lookup(bp.exPc, eh, etg, way);
      s = int'((bp.exPc >> 2) & 32'hF);
      if (eh && bp.exTaken) begin
        m_tgt[s][way] = bp.exTarget;
      end else if (!eh && bp.exTaken) begin
        victim = m_valid[s][0] == 0 ? 0 : (m_valid[s][1] == 0 ? 1 : m_rr[s]);
        m_valid[s][victim] = 1;
        m_tag[s][victim]   = bp.exPc >> 6;
        m_tgt[s][victim]   = bp.exTarget;
        m_rr[s] = (m_rr[s] + 1) % 2;
      end
    end
    m_ghr = new_ghr;
  endtask

  task automatic advance();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input bit v, input logic [31:0] pc, input bit tk,
                          input logic [31:0] tgt, input logic [7:0] ghr, input bit mis);
    bp.exValid = v; bp.exPc = pc; bp.exTaken = tk;
    bp.exTarget = tgt; bp.exGhr = ghr; bp.exMispredict = mis;
  endtask

  task automatic test_reset();
    bp.fetchValid = 1'b1;
    bp.fetchPc    = 32'h100;
    drive_ex(0, 32'h0, 0, 32'h0, 8'h00, 0);
    #1 rst = 1'b1;
    #1;
    n_total++; if (bp.fetchHit !== 1'b0) $display("FAIL reset_hit: got %b want 0", bp.fetchHit); else n_pass++;
    n_total++; if (bp.fetchTaken !== 1'b0) $display("FAIL reset_taken: got %b want 0", bp.fetchTaken); else n_pass++;
    n_total++; if (bp.fetchTarget !== 32'h0) $display("FAIL reset_target: got %h want 0", bp.fetchTarget); else n_pass++;
    n_total++; if (bp.fetchGhr !== 8'h00) $display("FAIL reset_ghr: got %h want 00", bp.fetchGhr); else n_pass++;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    bp.fetchValid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_allocate();
    bp.fetchValid = 1'b0;
    bp.fetchPc    = 32'h100;
    drive_ex(1, 32'h100, 1, 32'h200, 8'h00, 0);
    @(negedge clk);
    n_total++; if (bp.fetchHit !== 1'b0) $display("FAIL alloc_same_cycle_hit: got %b want 0", bp.fetchHit); else n_pass++;
    advance();
    bp.exValid = 1'b0;
    @(negedge clk);
    n_total++; if (bp.fetchHit !== 1'b1) $display("FAIL alloc_hit: got %b want 1", bp.fetchHit); else n_pass++;
    n_total++; if (bp.fetchTarget !== 32'h200) $display("FAIL alloc_target: got %h want 200", bp.fetchTarget); else n_pass++;
    n_total++; if (bp.fetchTaken !== 1'b1) $display("FAIL alloc_taken: got %b want 1", bp.fetchTaken); else n_pass++;
    advance();
  endtask

  task automatic test_saturation();
    bit e_taken [5] = '{0, 1, 1, 1, 1};
    bp.fetchValid = 1'b0;
    bp.fetchPc    = 32'h100;
    for (int i = 0; i < 4; i++) begin
      drive_ex(1, 32'h100, 0, 32'h0, 8'h00, 0);
      @(negedge clk);
      advance();
    end
    bp.exValid = 1'b0;
    #1;
    n_total++; if (bp.fetchHit !== 1'b1) $display("FAIL sat_nt_hit: got %b want 1", bp.fetchHit); else n_pass++;
    n_total++; if (bp.fetchTaken !== 1'b0) $display("FAIL sat_nt_taken: got %b want 0", bp.fetchTaken); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      drive_ex(1, 32'h100, 1, 32'h200, 8'h00, 0);
      @(negedge clk);
      advance();
      bp.exValid = 1'b0;
      #1;
      n_total++;
      if (bp.fetchTaken !== e_taken[i])
        $display("FAIL sat_t_taken[%0d]: got %b want %b", i, bp.fetchTaken, e_taken[i]);
      else n_pass++;
    end
    advance();
  endtask

  task automatic test_ghr_recovery();
    bp.fetchValid = 1'b1;
    bp.fetchPc    = 32'h100;
    drive_ex(1, 32'h300, 0, 32'h0, 8'h05, 1);
    @(negedge clk);
    n_total++; if (bp.fetchTaken !== 1'b1) $display("FAIL ghr_pred_taken: got %b want 1", bp.fetchTaken); else n_pass++;
    n_total++; if (bp.fetchGhr !== 8'h00) $display("FAIL ghr_pre: got %h want 00", bp.fetchGhr); else n_pass++;
    advance();
    bp.exValid = 1'b0;
    bp.fetchValid = 1'b0;
    #1;
    n_total++; if (bp.fetchGhr !== 8'h0A) $display("FAIL ghr_recover: got %h want 0a", bp.fetchGhr); else n_pass++;
    // Speculative shift on a predicted-taken hit (counter at 0x4A is weakly taken).
    bp.fetchValid = 1'b1;
    @(negedge clk);
    advance();
    n_total++; if (bp.fetchGhr !== 8'h15) $display("FAIL ghr_spec_shift: got %h want 15", bp.fetchGhr); else n_pass++;
    bp.fetchPc = 32'h3F0;
    @(negedge clk);
    advance();
    n_total++; if (bp.fetchGhr !== 8'h15) $display("FAIL ghr_miss_hold: got %h want 15", bp.fetchGhr); else n_pass++;
    bp.fetchValid = 1'b0;
  endtask

  task automatic test_replacement();
    logic [31:0] pcs  [3] = '{32'h140, 32'h180, 32'h1C0};
    bp.fetchValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_ex(1, pcs[i], 1, 32'h1000 | pcs[i], 8'h00, 0);
      @(negedge clk);
      advance();
    end
    bp.exValid = 1'b0;
    bp.fetchPc = 32'h100; #1;
    n_total++; if (bp.fetchHit !== 1'b0) $display("FAIL repl_evicted: got %b want 0", bp.fetchHit); else n_pass++;
    bp.fetchPc = 32'h140; #1;
    n_total++; if (bp.fetchTarget !== 32'h1140) $display("FAIL repl_140: got %h want 1140", bp.fetchTarget); else n_pass++;
    bp.fetchPc = 32'h180; #1;
    n_total++; if (bp.fetchTarget !== 32'h1180) $display("FAIL repl_180: got %h want 1180", bp.fetchTarget); else n_pass++;
    // Pointer now at way1, so the next allocation displaces 0x140.
    drive_ex(1, pcs[2], 1, 32'h11C0, 8'h00, 0);
    @(negedge clk);
    advance();
    bp.exValid = 1'b0;
    bp.fetchPc = 32'h140; #1;
    n_total++; if (bp.fetchHit !== 1'b0) $display("FAIL repl_rr_evict: got %b want 0", bp.fetchHit); else n_pass++;
    bp.fetchPc = 32'h180; #1;
    n_total++; if (bp.fetchHit !== 1'b1) $display("FAIL repl_rr_keep: got %b want 1", bp.fetchHit); else n_pass++;
    advance();
  endtask

  task automatic test_random();
    bit e_hit, e_taken;
    logic [31:0] e_tgt;
    for (int n = 0; n < 300; n++) begin
      bp.fetchValid = 1'($urandom_range(0, 1));
      bp.fetchPc    = ($urandom_range(1, 3) << 6) | ($urandom_range(0, 3) << 2);
      drive_ex(1'($urandom_range(0, 1)),
               ($urandom_range(1, 3) << 6) | ($urandom_range(0, 3) << 2),
               1'($urandom_range(0, 1)), $urandom,
               $urandom_range(0, 1) ? 8'(m_ghr) : 8'($urandom),
               ($urandom_range(0, 3) == 0));
      @(negedge clk);
      m_predict(bp.fetchPc, e_hit, e_taken, e_tgt);
      n_total++; if (bp.fetchHit !== e_hit) $display("FAIL rand_hit[%0d]: got %b want %b", n, bp.fetchHit, e_hit); else n_pass++;
      n_total++; if (bp.fetchTaken !== e_taken) $display("FAIL rand_taken[%0d]: got %b want %b", n, bp.fetchTaken, e_taken); else n_pass++;
      n_total++; if (bp.fetchTarget !== e_tgt) $display("FAIL rand_target[%0d]: got %h want %h", n, bp.fetchTarget, e_tgt); else n_pass++;
      n_total++; if (bp.fetchGhr !== 8'(m_ghr)) $display("FAIL rand_ghr[%0d]: got %h want %h", n, bp.fetchGhr, 8'(m_ghr)); else n_pass++;
      advance();
    end
    drive_ex(0, 32'h0, 0, 32'h0, 8'h00, 0);
    bp.fetchValid = 1'b0;
  endtask

  task automatic test_async_reset();
    bp.fetchValid = 1'b0;
    bp.fetchPc    = 32'h7C4;
    drive_ex(1, 32'h7C4, 1, 32'hABC, 8'h00, 0);
    @(negedge clk);
    advance();
    bp.exValid = 1'b0;
    #1;
    n_total++; if (bp.fetchHit !== 1'b1) $display("FAIL areset_pre_hit: got %b want 1", bp.fetchHit); else n_pass++;
    drive_ex(1, 32'h844, 1, 32'h123, 8'h00, 1);
    bp.fetchValid = 1'b1;
    rst = 1'b1;
    #1;
    n_total++; if (bp.fetchHit !== 1'b0) $display("FAIL areset_hit_drop: got %b want 0", bp.fetchHit); else n_pass++;
    n_total++; if (bp.fetchTarget !== 32'h0) $display("FAIL areset_target: got %h want 0", bp.fetchTarget); else n_pass++;
    n_total++; if (bp.fetchGhr !== 8'h00) $display("FAIL areset_ghr: got %h want 00", bp.fetchGhr); else n_pass++;
    m_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    drive_ex(0, 32'h0, 0, 32'h0, 8'h00, 0);
    bp.fetchValid = 1'b0;
    #1;
    n_total++; if (bp.fetchHit !== 1'b0) $display("FAIL areset_post_7c4: got %b want 0", bp.fetchHit); else n_pass++;
    bp.fetchPc = 32'h844; #1;
    n_total++; if (bp.fetchHit !== 1'b0) $display("FAIL areset_discard_844: got %b want 0", bp.fetchHit); else n_pass++;
    n_total++; if (bp.fetchGhr !== 8'h00) $display("FAIL areset_post_ghr: got %h want 00", bp.fetchGhr); else n_pass++;
    drive_ex(1, 32'h844, 1, 32'h123, 8'h00, 0);
    @(negedge clk);
    advance();
    bp.exValid = 1'b0;
    #1;
    n_total++; if (bp.fetchTarget !== 32'h123) $display("FAIL areset_first_update: got %h want 123", bp.fetchTarget); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_saturation();
    test_ghr_recovery();
    test_replacement();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
